ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits between PS2_Controller and the tone/LED logic.
- Consumes the raw scan-code byte stream: received_data, qualified by the received_data_en strobe.
- Tracks make/break and E0-extended prefixes with a state machine and keeps a per-key held state for up, down, left, right and space.
- Emits a priority-encoded active key, so that several keys held together give one defined tone, and a one-cycle pulse on every key-state change.

Parameters:
- TIMEOUT_CYCLES, 2500000: CLOCK_50 cycles (50 ms) a prefix may wait for its next byte. Used only with PS2_PREFIX_TIMEOUT_EN.

Ports:
- CLOCK_50  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- received_data  input  8  scan-code byte from PS2_Controller.
- received_data_en  input  1  one-cycle strobe; received_data is valid on that cycle.
- key_state  output  5  held keys: [0]=up, [1]=down, [2]=right, [3]=left, [4]=space.
- any_key  output  1  OR of key_state.
- active_key  output  3  0=none, 1=up, 2=down, 3=left, 4=right, 5=space.
- key_event  output  1  one-cycle pulse when any key_state bit changes.
- key_event_make  output  1  with key_event: 1=press, 0=release.
- key_event_id  output  3  with key_event: key id, same encoding as active_key.

Behaviour:
- Reset: FSM goes to IDLE. key_state=0, any_key=0, active_key=0, key_event=0, key_event_make=0, key_event_id=0, timeout counter=0.
- A byte is processed only on a cycle where received_data_en=1. Back-to-back strobes on consecutive cycles are each processed.
- All outputs are registered. They update on the edge after the strobe cycle (latency 1).
- Key codes: 75=up, 72=down, 74=right, 6B=left, 29=space. The four arrow codes are accepted with or without the E0 prefix (keypad aliases).
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - Key code -> make, stay IDLE.
  - Any other byte (FA, AA, EE, FE, E1, unknown) -> ignored, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - Key code -> make, then IDLE.
  - Other byte -> IDLE, no change.
- BRK:
  - E0 -> EXT_BRK.
  - F0 -> stay BRK.
  - Key code -> break, then IDLE.
  - Other byte -> IDLE, no change.
- EXT_BRK:
  - E0 or F0 -> stay EXT_BRK.
  - Key code -> break, then IDLE.
  - Other byte -> IDLE, no change.
- Make sets the key's bit; break clears it. A break clears only its own key; other held keys are unaffected.
- Typematic repeat (make of an already-set key) and break of an already-clear key: no change and no key_event.
- key_event is asserted for exactly one cycle, only when a bit actually toggles. key_event_make and key_event_id are valid on that cycle and hold their value otherwise.
- active_key priority: up > down > left > right > space. It is recomputed from the next key_state value, so it is updated in the same cycle as key_state.
- any_key and active_key are consistent with key_state every cycle.
- Reset asserted mid-sequence (for example after E0 F0): the prefix is discarded. The following key byte is then treated as a make from IDLE.

Optional Feature:
- Macro PS2_PREFIX_TIMEOUT_EN.
- Defined:
  - A counter clears on every strobe and increments while the FSM is not in IDLE and no strobe arrives.
  - When the counter reaches TIMEOUT_CYCLES-1 with no strobe, the FSM returns to IDLE and the counter clears.
  - key_state is unchanged and no event is generated.
  - A strobe on the timeout cycle takes priority: the byte is processed in the current state.
- Undefined:
  - There is no counter. Prefix states persist until the next byte arrives. TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, then bytes 75, F0, 75 -> key_state 00001 then 00000. key_event pulses twice (make=1 id=1, then make=0 id=1). active_key 1 then 0.
- E0 6B, E0 74, then E0 F0 6B -> key_state 01000, then 01100, then 00100. active_key 3, 3, 4. Three key_event pulses.
- Space held with repeat 29, 29, 29 -> a single key_event. key_state 10000 holds; active_key=5.
- Interleaved noise AA, FA, E0 FE, then 72 -> only down is set (key_state 00010). No events for the noise bytes.
- Reset asserted after E0 F0, then 75 -> after reset all outputs 0. 75 then gives a make: key_state 00001 and key_event make=1.
- Timeout (with PS2_PREFIX_TIMEOUT_EN, TIMEOUT_CYCLES=100): F0, wait 150 cycles, then 29 -> make, key_state 10000. Without the macro, the same stimulus gives a break: key_state stays 00000 and no event.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes, holds up/down/left/right/space state,
// priority-encodes the active key and pulses on every key-state change.
// Optional prefix timeout is enabled with the PS2_PREFIX_TIMEOUT_EN macro.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [4:0] key_state,
  output logic       any_key,
  output logic [2:0] active_key,
  output logic       key_event,
  output logic       key_event_make,
  output logic [2:0] key_event_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic       timeout_s;
  logic [4:0] key_mask_s;
  logic       is_break_s;
  logic [4:0] key_state_next_s;
  logic       event_s;
  logic       event_make_s;
  logic [2:0] event_id_s;

  // One-hot key_state bit for a scan code; zero for anything that is not a tracked key.
  function automatic logic [4:0] decode_key(input logic [7:0] code);
    case (code)
      8'h75:   decode_key = 5'b00001;
      8'h72:   decode_key = 5'b00010;
      8'h74:   decode_key = 5'b00100;
      8'h6B:   decode_key = 5'b01000;
      8'h29:   decode_key = 5'b10000;
      default: decode_key = 5'b00000;
    endcase
  endfunction

  function automatic logic [2:0] mask_to_id(input logic [4:0] mask);
    case (mask)
      5'b00001: mask_to_id = 3'd1;
      5'b00010: mask_to_id = 3'd2;
      5'b01000: mask_to_id = 3'd3;
      5'b00100: mask_to_id = 3'd4;
      5'b10000: mask_to_id = 3'd5;
      default:  mask_to_id = 3'd0;
    endcase
  endfunction

  // up > down > left > right > space
  function automatic logic [2:0] priority_id(input logic [4:0] ks);
    if (ks[0])      priority_id = 3'd1;
    else if (ks[1]) priority_id = 3'd2;
    else if (ks[3]) priority_id = 3'd3;
    else if (ks[2]) priority_id = 3'd4;
    else if (ks[4]) priority_id = 3'd5;
    else            priority_id = 3'd0;
  endfunction

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;

  logic [CNT_W-1:0] timeout_cnt_r;

  assign timeout_s = !received_data_en && (state_r != ST_IDLE) &&
                     (timeout_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'd1));

  // Prefix age counter: runs only while a prefix waits for its next byte.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      timeout_cnt_r <= {CNT_W{1'b0}};
    end else if (received_data_en || (state_r == ST_IDLE) || timeout_s) begin
      timeout_cnt_r <= {CNT_W{1'b0}};
    end else begin
      timeout_cnt_r <= timeout_cnt_r + CNT_W'(1);
    end
  end
`else
  logic [31:0] unused_timeout_s;

  assign unused_timeout_s = TIMEOUT_CYCLES;
  assign timeout_s        = 1'b0;
`endif

  // Prefix state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Prefix transitions; a strobe on the timeout cycle wins over the timeout.
  always_comb begin
    state_next_s = state_r;
    if (received_data_en) begin
      case (state_r)
        ST_IDLE: begin
          if (received_data == 8'hE0)      state_next_s = ST_EXT;
          else if (received_data == 8'hF0) state_next_s = ST_BRK;
          else                             state_next_s = ST_IDLE;
        end
        ST_EXT: begin
          if (received_data == 8'hF0)      state_next_s = ST_EXT_BRK;
          else if (received_data == 8'hE0) state_next_s = ST_EXT;
          else                             state_next_s = ST_IDLE;
        end
        ST_BRK: begin
          if (received_data == 8'hE0)      state_next_s = ST_EXT_BRK;
          else if (received_data == 8'hF0) state_next_s = ST_BRK;
          else                             state_next_s = ST_IDLE;
        end
        ST_EXT_BRK: begin
          if ((received_data == 8'hE0) || (received_data == 8'hF0)) state_next_s = ST_EXT_BRK;
          else                                                       state_next_s = ST_IDLE;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else if (timeout_s) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_r;
    end
  end

  // Key-state update and event generation for the byte on this strobe.
  always_comb begin
    key_mask_s       = decode_key(received_data);
    is_break_s       = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
    key_state_next_s = key_state;
    event_s          = 1'b0;
    event_make_s     = key_event_make;
    event_id_s       = key_event_id;
    if (received_data_en && (key_mask_s != 5'b00000)) begin
      if (is_break_s) begin
        key_state_next_s = key_state & ~key_mask_s;
      end else begin
        key_state_next_s = key_state | key_mask_s;
      end
      if (key_state_next_s != key_state) begin
        event_s      = 1'b1;
        event_make_s = !is_break_s;
        event_id_s   = mask_to_id(key_mask_s);
      end else begin
        event_s      = 1'b0;
      end
    end else begin
      key_state_next_s = key_state;
    end
  end

  // Registered outputs, all derived from the next key state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_state      <= 5'b00000;
      any_key        <= 1'b0;
      active_key     <= 3'd0;
      key_event      <= 1'b0;
      key_event_make <= 1'b0;
      key_event_id   <= 3'd0;
    end else begin
      key_state      <= key_state_next_s;
      any_key        <= |key_state_next_s;
      active_key     <= priority_id(key_state_next_s);
      key_event      <= event_s;
      key_event_make <= event_make_s;
      key_event_id   <= event_id_s;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected key events are queued as bytes are
// driven and matched when key_event pulses; held-key outputs are checked after each byte.
module tb_ps2_key_decoder;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [4:0] key_state;
  logic       any_key;
  logic [2:0] active_key;
  logic       key_event;
  logic       key_event_make;
  logic [2:0] key_event_id;

  int checks   = 0;
  int failures = 0;
  logic [3:0] ev_q[$];

  ps2_key_decoder #(.TIMEOUT_CYCLES(32'd100)) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .key_state        (key_state),
    .any_key          (any_key),
    .active_key       (active_key),
    .key_event        (key_event),
    .key_event_make   (key_event_make),
    .key_event_id     (key_event_id)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one strobed byte; returns at the negedge after the processing edge.
  task automatic drive_byte(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic idle(input int n);
    received_data_en = 1'b0;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic expect_event(input logic make, input logic [2:0] id);
    ev_q.push_back({make, id});
  endtask

  task automatic check_keys(input string tag, input logic [4:0] st, input logic [2:0] act);
    check_value({tag, "_state"}, 32'(key_state), 32'(st));
    check_value({tag, "_any"}, 32'(any_key), 32'(|st));
    check_value({tag, "_active"}, 32'(active_key), 32'(act));
  endtask

  // Event monitor: every key_event pulse must match the oldest queued expectation.
  always @(negedge CLOCK_50) begin
    logic [3:0] exp_ev;
    if (!reset && key_event) begin
      if (ev_q.size() == 0) begin
        check_value("unexpected_event", {28'd0, key_event_make, key_event_id}, 32'd0);
      end else begin
        exp_ev = ev_q.pop_front();
        check_value("event_make", 32'(key_event_make), 32'(exp_ev[3]));
        check_value("event_id", 32'(key_event_id), 32'(exp_ev[2:0]));
      end
    end
  end

  initial begin
    reset            = 1'b1;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_keys("reset", 5'b00000, 3'd0);
    check_value("reset_event", 32'(key_event), 32'd0);
    reset = 1'b0;
    idle(2);

    // Make then break of up
    expect_event(1'b1, 3'd1);
    drive_byte(8'h75); check_keys("up_make", 5'b00001, 3'd1);
    drive_byte(8'hF0); check_keys("up_f0", 5'b00001, 3'd1);
    expect_event(1'b0, 3'd1);
    drive_byte(8'h75); check_keys("up_break", 5'b00000, 3'd0);
    idle(3);

    // Extended left/right with priority
    drive_byte(8'hE0);
    expect_event(1'b1, 3'd3);
    drive_byte(8'h6B); check_keys("left_make", 5'b01000, 3'd3);
    drive_byte(8'hE0);
    expect_event(1'b1, 3'd4);
    drive_byte(8'h74); check_keys("right_make", 5'b01100, 3'd3);
    drive_byte(8'hE0); drive_byte(8'hF0);
    expect_event(1'b0, 3'd3);
    drive_byte(8'h6B); check_keys("left_break", 5'b00100, 3'd4);
    drive_byte(8'hE0); drive_byte(8'hF0);
    expect_event(1'b0, 3'd4);
    drive_byte(8'h74); check_keys("right_break", 5'b00000, 3'd0);
    idle(2);

    // Space typematic repeat gives a single event
    expect_event(1'b1, 3'd5);
    drive_byte(8'h29); check_keys("space_make", 5'b10000, 3'd5);
    drive_byte(8'h29); check_keys("space_rep1", 5'b10000, 3'd5);
    idle(1);
    drive_byte(8'h29); check_keys("space_rep2", 5'b10000, 3'd5);
    drive_byte(8'hF0);
    expect_event(1'b0, 3'd5);
    drive_byte(8'h29); check_keys("space_break", 5'b00000, 3'd0);
    idle(2);

    // Noise bytes, then down
    drive_byte(8'hAA); drive_byte(8'hFA); drive_byte(8'hE0); drive_byte(8'hFE);
    check_keys("noise", 5'b00000, 3'd0);
    expect_event(1'b1, 3'd2);
    drive_byte(8'h72); check_keys("down_make", 5'b00010, 3'd2);
    expect_event(1'b1, 3'd1);
    drive_byte(8'h75); check_keys("up_down", 5'b00011, 3'd1);
    drive_byte(8'hF0);
    drive_byte(8'h6B); check_keys("break_clear_key", 5'b00011, 3'd1);
    idle(2);

    // Reset after E0 F0 discards the prefix
    drive_byte(8'hE0); drive_byte(8'hF0);
    received_data_en = 1'b0;
    reset = 1'b1;
    @(negedge CLOCK_50);
    check_keys("mid_reset", 5'b00000, 3'd0);
    check_value("mid_reset_event", 32'(key_event), 32'd0);
    check_value("mid_reset_make", 32'(key_event_make), 32'd0);
    check_value("mid_reset_id", 32'(key_event_id), 32'd0);
    reset = 1'b0;
    idle(1);
    expect_event(1'b1, 3'd1);
    drive_byte(8'h75); check_keys("post_reset_make", 5'b00001, 3'd1);

    // F0 then unknown byte returns to IDLE; next key is a make
    drive_byte(8'hF0); drive_byte(8'h12);
    expect_event(1'b1, 3'd2);
    drive_byte(8'h72); check_keys("brk_abort", 5'b00011, 3'd1);
    drive_byte(8'hE0); drive_byte(8'hE0);
    drive_byte(8'h72); check_keys("ext_ext_rep", 5'b00011, 3'd1);
    drive_byte(8'hE0); drive_byte(8'hF0); drive_byte(8'hF0);
    expect_event(1'b0, 3'd2);
    drive_byte(8'h72); check_keys("ext_brk_f0", 5'b00001, 3'd1);
    drive_byte(8'hF0);
    expect_event(1'b0, 3'd1);
    drive_byte(8'h75); check_keys("up_release", 5'b00000, 3'd0);
    idle(2);

    // Prefix timeout behaviour
    drive_byte(8'hF0);
    idle(150);
`ifdef PS2_PREFIX_TIMEOUT_EN
    expect_event(1'b1, 3'd5);
    drive_byte(8'h29); check_keys("timeout_make", 5'b10000, 3'd5);
`else
    drive_byte(8'h29); check_keys("no_timeout_break", 5'b00000, 3'd0);
`endif
    idle(5);

    check_value("scoreboard_empty", 32'(ev_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
